// File: rtl/div_ctrl.sv
// Two-requester round-robin front end around a serial unsigned restoring divider.
// Optional macro DIV_CTRL_DZ_TRAP_EN: divide-by-zero finishes in one cycle and raises res_dz.
module div_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_q,
    output logic [WIDTH-1:0] res_r,
    output logic             res_id,
    output logic             res_dz,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               ptr;
    logic               grant_id;
    logic               accept;
    logic               last_iter;
    logic               trap;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH-1:0]   q_work;
    logic [WIDTH-1:0]   b_work;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH-1:0]   r_nxt;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH:0]     diff;
    logic [CNT_W-1:0]   cnt;
    logic               id_work;

    // Round-robin pick: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant_id = req1_valid & (~req0_valid | ptr);
        a_sel    = grant_id ? req1_a : req0_a;
        b_sel    = grant_id ? req1_b : req0_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        last_iter  = 1'b0;
        trap       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid & ~grant_id;
                req1_ready = grant_id;
                accept     = req0_valid | req1_valid;
                if (accept) begin
                    state_nxt = RUN;
`ifdef DIV_CTRL_DZ_TRAP_EN
                    if (b_sel == '0) begin
                        trap      = 1'b1;
                        state_nxt = DONE;
                    end
`endif
                end
            end
            RUN: begin
                last_iter = (cnt == CNT_W'(WIDTH - 1));
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step; the (WIDTH+1)-bit difference sign decides keep vs restore.
    always_comb begin
        r_shift = {r_work, q_work[WIDTH-1]};
        diff    = r_shift - {1'b0, b_work};
        if (!diff[WIDTH]) begin
            r_nxt = diff[WIDTH-1:0];
            q_nxt = {q_work[WIDTH-2:0], 1'b1};
        end else begin
            r_nxt = r_shift[WIDTH-1:0];
            q_nxt = {q_work[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            res_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_work  <= '0;
            b_work  <= '0;
            r_work  <= '0;
            cnt     <= '0;
            id_work <= 1'b0;
            ptr     <= 1'b0;
            res_q   <= '0;
            res_r   <= '0;
            res_id  <= 1'b0;
        end else if (accept) begin
            q_work  <= a_sel;
            b_work  <= b_sel;
            r_work  <= '0;
            cnt     <= '0;
            id_work <= grant_id;
            ptr     <= ~grant_id;
            if (trap) begin
                res_q  <= '1;
                res_r  <= a_sel;
                res_id <= grant_id;
            end
        end else if (state == RUN) begin
            q_work <= q_nxt;
            r_work <= r_nxt;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
                res_q  <= q_nxt;
                res_r  <= r_nxt;
                res_id <= id_work;
            end
        end
    end

`ifdef DIV_CTRL_DZ_TRAP_EN
    // Zero-divisor flag follows whichever path produced the current result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_dz <= 1'b0;
        end else if (accept && trap) begin
            res_dz <= 1'b1;
        end else if (state == RUN && last_iter) begin
            res_dz <= 1'b0;
        end
    end
`else
    assign res_dz = 1'b0;
`endif

endmodule
